la_rrarb: RTL and testbench
===========================

Name: la_rrarb

Overview:
- Round-robin arbiter that time-shares one downstream resource among N requesters.
- Example resource: a shared OAI/AOI-built mux or bus driver in a stdlib-level datapath.
- Registered one-hot grant with a rotating priority pointer; fair, starvation-free service.
- Sits between requester logic and the shared cell's select inputs. It is the sequencing layer above the combinational gate library.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- MAXHOLD, 8, maximum consecutive grant cycles for one requester; used only when the hold feature is compiled in; legal range 1..255.
- PROP, "DEFAULT", implementation property string passed through for technology mapping; no functional effect.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low forces no new grant.
- req  input  N  request vector, one bit per requester, level-sensitive.
- grant  output  N  registered one-hot (or zero) grant.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  $clog2(N)  binary index of the granted requester; 0 when grant_valid is 0.

Behaviour:
- Reset (nreset low, asynchronous): grant=0, grant_valid=0, grant_id=0, ptr=0, state=IDLE, hold counter=0. Outputs stay at these values while nreset is low. Release is synchronous to the next clk edge.
- ptr ($clog2(N) bits) is the highest-priority index.
- Winner = first set bit of req scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
- Latency: req at edge k produces grant visible after edge k+1. No combinational path from req to grant.
- States: IDLE (no grant) and GRANT (one grant asserted).
- IDLE -> GRANT: en=1 and req!=0. Register the winner's grant; ptr <= (winner+1) mod N, so winner N-1 wraps ptr to 0.
- IDLE -> IDLE: en=0 or req=0.
- GRANT without hold feature: every grant lasts exactly one cycle; arbitration re-runs every cycle with the updated ptr.
  - Continuous requests get back-to-back grants to successive requesters.
  - If req=0 or en=0, next state is IDLE.
- en deasserted in any state: grant cleared at the next edge; ptr retained.
- Requester drops req during its grant cycle: no effect on the current grant; it is not granted next cycle.
- Single active requester: granted every cycle (without hold) regardless of ptr.
- req bits set and cleared in the same cycle as arbitration: only the sampled value at the edge matters.
- Invariants: grant has at most one bit set; grant_id is consistent with grant every cycle.

Optional Feature:
- Macro: LA_RRARB_HOLD_EN.
- Defined: in GRANT, the grant is held while the granted requester's req stays 1 and en=1. A hold counter increments each held cycle.
- Defined, release conditions:
  - req drops: grant cleared next edge, then re-arbitrate.
  - counter reaches MAXHOLD: forced release; grant passes to the next winner (excluding current holder if others request) on the following edge; counter resets to 0.
- Defined, ptr update: ptr advances only when the grant is first issued, not during hold.
- Not defined: single-cycle grants as described above; counter logic absent; MAXHOLD ignored.

Decomposition:
- Shared package la_stdlib_pkg holds:
  - state encoding localparams LA_ARB_IDLE=1'b0, LA_ARB_GRANT=1'b1;
  - a clog2 width helper function.
- One natural sub-module: la_rrarb_pick. It is purely combinational: rotate req by ptr, find-first-set, rotate back. Outputs one-hot winner and binary index.
- la_rrarb instantiates la_rrarb_pick once and owns all registers.

Test Plan:
- Reset: nreset=0 with req=4'b1111, en=1 -> grant=0, grant_valid=0, grant_id=0 throughout; release -> first grant 4'b0001 one cycle later.
- Full contention, N=4, no hold: req=4'b1111 held 8 cycles -> grant sequence 0001,0010,0100,1000,0001,… with grant_id 0,1,2,3,0.
- Wrap and skip: ptr=3 (after granting 2), req=4'b0101 -> grant 0001, then 0100, then 0001.
- Enable and async reset mid-operation: en dropped during grant 0010 -> grant=0 next cycle, ptr kept; en reasserted with req=4'b1111 -> 0100. nreset pulsed low mid-grant -> grant cleared immediately, ptr=0.
- Hold feature (LA_RRARB_HOLD_EN, MAXHOLD=3): req=4'b0011 constant -> 0001 held 3 cycles, then 0010 held 3 cycles, alternating. req[0] dropped after 1 cycle of grant -> 0010 granted next cycle.
- Single requester: req=4'b1000 continuous, no hold -> grant=1000 every cycle, grant_id=3, grant_valid=1.

Source files
------------

// File: rtl/la_stdlib_pkg.sv
// rtl/la_stdlib_pkg.sv - shared arbiter state encoding and width helper
package la_stdlib_pkg;

    localparam logic LA_ARB_IDLE  = 1'b0;
    localparam logic LA_ARB_GRANT = 1'b1;

    function automatic int la_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/la_rrarb_pick.sv
// rtl/la_rrarb_pick.sv - combinational round-robin winner select
// Rotates req so ptr lands at bit 0, takes the lowest set bit, rotates the index back.
module la_rrarb_pick
    import la_stdlib_pkg::*;
#(
    parameter int N = 4,
    parameter int W = la_clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win,
    output logic [W-1:0] win_id,
    output logic         win_any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    int             sum;

    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        off     = '0;
        win_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = W'(i);
                win_any = 1'b1;
            end
        end
        sum = int'(ptr) + int'(off);
        if (sum >= N) begin
            sum = sum - N;
        end
        win_id = W'(sum);
        win    = '0;
        if (win_any) begin
            win[win_id] = 1'b1;
        end
    end

endmodule

// File: rtl/la_rrarb.sv
// rtl/la_rrarb.sv - registered round-robin arbiter with rotating priority pointer
// Optional grant hold up to MAXHOLD cycles when LA_RRARB_HOLD_EN is defined.
module la_rrarb
    import la_stdlib_pkg::*;
#(
    parameter int    N       = 4,
    parameter int    MAXHOLD = 8,
    parameter string PROP    = "DEFAULT"
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int W = la_clog2(N);

    logic         state_q;
    logic         state_d;
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic [N-1:0] grant_d;
    logic [W-1:0] id_d;
    logic [N-1:0] win;
    logic [W-1:0] win_id;
    logic         win_any;
    logic         hold_ok;
    logic         hold;

    // PROP only steers technology mapping; degenerate settings add nothing here.
    if (PROP == "" || MAXHOLD < 1 || N < 2) begin : g_cfg_ref
    end

    la_rrarb_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .win    (win),
        .win_id (win_id),
        .win_any(win_any)
    );

`ifdef LA_RRARB_HOLD_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign hold_ok = en && req[grant_id] && (cnt_q < 8'(MAXHOLD));

    // Counter holds the number of cycles the current grant has been visible.
    always_comb begin
        cnt_d = 8'd0;
        if (hold) begin
            cnt_d = cnt_q + 8'd1;
        end else if (en && win_any) begin
            cnt_d = 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign hold_ok = 1'b0;
`endif

    assign hold = (state_q == LA_ARB_GRANT) && hold_ok;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= LA_ARB_IDLE;
            ptr_q       <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant       <= grant_d;
            grant_valid <= |grant_d;
            grant_id    <= id_d;
        end
    end

    always_comb begin
        state_d = LA_ARB_IDLE;
        if (hold || (en && win_any)) begin
            state_d = LA_ARB_GRANT;
        end
    end

    // Pointer moves only when a fresh grant is issued, never while holding.
    always_comb begin
        grant_d = '0;
        id_d    = '0;
        ptr_d   = ptr_q;
        if (hold) begin
            grant_d = grant;
            id_d    = grant_id;
        end else if (en && win_any) begin
            grant_d = win;
            id_d    = win_id;
            ptr_d   = (win_id == W'(N - 1)) ? '0 : win_id + W'(1);
        end
    end

endmodule

// File: tb/tb_la_rrarb.sv
// tb/tb_la_rrarb.sv - self-checking bench for la_rrarb (either LA_RRARB_HOLD_EN build)
module tb_la_rrarb;

    localparam int N       = 4;
    localparam int MAXHOLD = 3;
    localparam int W       = 2;

    logic         clk = 1'b0;
    logic         nreset;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [W-1:0] grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    int m_ptr;
    int m_holder;
    int m_run;
    int m_w;
    bit m_keep;

    always #5 clk = ~clk;

    la_rrarb #(
        .N      (N),
        .MAXHOLD(MAXHOLD),
        .PROP   ("DEFAULT")
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .en         (en),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        return (m_holder < 0) ? '0 : N'(1 << m_holder);
    endfunction

    // Reference model: who holds the resource, for how long, and where priority starts.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_ptr    = 0;
            m_holder = -1;
            m_run    = 0;
        end else begin
            m_keep = 1'b0;
`ifdef LA_RRARB_HOLD_EN
            m_keep = (m_holder >= 0) && en && req[m_holder] && (m_run < MAXHOLD);
`endif
            if (m_keep) begin
                m_run++;
            end else begin
                m_w = rr_pick(req, m_ptr);
                if (en && m_w >= 0) begin
                    m_holder = m_w;
                    m_run    = 1;
                    m_ptr    = (m_w + 1) % N;
                end else begin
                    m_holder = -1;
                    m_run    = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("grant", grant, m_grant());
        check("grant_valid", grant_valid, (m_holder >= 0) ? 1 : 0);
        check("grant_id", grant_id, (m_holder < 0) ? 0 : m_holder);
        check("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    end

    task automatic cyc(input logic e, input logic [N-1:0] r);
        @(negedge clk);
        en  = e;
        req = r;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [N-1:0] g);
        check(nm, grant, g);
        check({"model_", nm}, m_grant(), g);
    endtask

    initial begin
        logic [N-1:0] seq [8];
        nreset = 1'b0;
        en     = 1'b1;
        req    = 4'b1111;
        repeat (3) begin
            @(posedge clk);
            #2;
            lit("reset", 4'b0000);
            check("reset_valid", grant_valid, 0);
            check("reset_id", grant_id, 0);
        end
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #2;
        lit("release", 4'b0001);

`ifndef LA_RRARB_HOLD_EN
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 4'b1111);
            lit("contention", seq[i]);
            check("contention_id", grant_id, i % 4);
        end
        cyc(1'b1, 4'b1111); lit("pre_wrap0", 4'b0001);
        cyc(1'b1, 4'b1111); lit("pre_wrap1", 4'b0010);
        cyc(1'b1, 4'b1111); lit("pre_wrap2", 4'b0100);
        cyc(1'b1, 4'b0101); lit("wrap0", 4'b0001);
        cyc(1'b1, 4'b0101); lit("wrap1", 4'b0100);
        cyc(1'b1, 4'b0101); lit("wrap2", 4'b0001);
        cyc(1'b1, 4'b1111); lit("en_pre", 4'b0010);
        cyc(1'b0, 4'b1111); lit("en_low", 4'b0000);
        cyc(1'b1, 4'b1111); lit("en_back", 4'b0100);
        #1;
        nreset = 1'b0;
        #1;
        lit("async_rst", 4'b0000);
        check("async_rst_id", grant_id, 0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #2;
        lit("after_rst", 4'b0001);
        cyc(1'b1, 4'b0000); lit("no_req", 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'b1000);
            lit("single", 4'b1000);
            check("single_id", grant_id, 3);
            check("single_valid", grant_valid, 1);
        end
        cyc(1'b1, 4'b1111); lit("drop_pre", 4'b0001);
        cyc(1'b1, 4'b1110); lit("drop", 4'b0010);
`else
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 4'b0011);
            lit("hold", seq[i]);
        end
        cyc(1'b1, 4'b0011); lit("hold_last", 4'b0001);
        cyc(1'b1, 4'b0011); lit("hold_b0", 4'b0010);
        cyc(1'b1, 4'b0011); lit("hold_b1", 4'b0010);
        cyc(1'b1, 4'b0011); lit("hold_b2", 4'b0010);
        cyc(1'b1, 4'b0011); lit("hold_a", 4'b0001);
        cyc(1'b1, 4'b0010); lit("hold_drop", 4'b0010);
        cyc(1'b0, 4'b0010); lit("hold_en_low", 4'b0000);
`endif
        repeat (3) cyc(1'b1, 4'b1010);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
